// File: rtl/ysyx_23060229_ifu_pkg.sv
// rtl/ysyx_23060229_ifu_pkg.sv - shared constants for the instruction fetch unit
package ysyx_23060229_ifu_pkg;

  localparam int          IFU_XLEN               = 32;
  localparam logic [31:0] ysyx_23060229_RESET_PC = 32'h8000_0000;

  typedef logic [1:0] ifu_state_t;

  localparam ifu_state_t IFU_REQ  = 2'd0;
  localparam ifu_state_t IFU_WAIT = 2'd1;
  localparam ifu_state_t IFU_FULL = 2'd2;

endpackage

// File: rtl/ysyx_23060229_ifu.sv
// rtl/ysyx_23060229_ifu.sv - single-outstanding fetch unit with a one-entry instruction slot
module ysyx_23060229_ifu
  import ysyx_23060229_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ysyx_23060229_RESET_PC,
  parameter int          XLEN     = IFU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc
);

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            req_valid_q, req_valid_d;
  logic            inst_valid_q, inst_valid_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_err_q, inst_err_d;
  logic            req_fire;

  assign req_fire       = req_valid_q & imem_req_ready;
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_err       = inst_err_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_err_d   = inst_err_q;

    if (redir_valid) begin
      // A redirect squashes the slot and marks any in-flight response as stale.
      pc_d         = {redir_pc[XLEN-1:2], 2'b00};
      inst_valid_d = 1'b0;
      case (state_q)
        IFU_REQ: begin
          if (req_fire) begin
            state_d = IFU_WAIT;
            drop_d  = 1'b1;
          end else begin
            state_d = IFU_REQ;
          end
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = IFU_REQ;
            drop_d  = 1'b0;
          end else begin
            state_d = IFU_WAIT;
            drop_d  = 1'b1;
          end
        end
        default: state_d = IFU_REQ;
      endcase
    end else begin
      case (state_q)
        IFU_REQ: begin
          if (req_fire) state_d = IFU_WAIT;
        end
        IFU_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = IFU_REQ;
            end else begin
              inst_d       = imem_rsp_data;
              inst_pc_d    = pc_q;
              inst_err_d   = imem_rsp_err;
              inst_valid_d = 1'b1;
              state_d      = IFU_FULL;
            end
          end
        end
        IFU_FULL: begin
          if (inst_ready) begin
            inst_valid_d = 1'b0;
            pc_d         = pc_q + XLEN'(4);
            state_d      = IFU_REQ;
          end
        end
        default: state_d = IFU_REQ;
      endcase
    end

    // Registered request valid keeps the request low for the first cycle out of reset.
    req_valid_d = (state_d == IFU_REQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IFU_REQ;
      pc_q         <= RESET_PC[XLEN-1:0];
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060229_ifu.sv
// tb/tb_ysyx_23060229_ifu.sv - randomized bench for the fetch unit against a transaction-level model
module tb_ysyx_23060229_ifu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        imem_rsp_err   = 1'b0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        redir_valid    = 1'b0;
  logic [31:0] redir_pc       = '0;

  always #5 clk = ~clk;

  ysyx_23060229_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model: architectural pc, whether a request is being offered, whether one is in flight,
  // whether the in-flight one is stale, and the slot contents.
  logic [31:0] m_pc;
  bit          m_req_on, m_out, m_drop, m_slot_v, m_ierr;
  logic [31:0] m_inst, m_ipc;

  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;
  int          err_pct;
  bit          rand_data;
  bit          stray;
  bit          cmp_en = 1'b0;
  logic [31:0] err_addr;
  int          cycle_no = 0;
  logic [31:0] fires[$];
  int          fire_cyc[$];
  logic [31:0] hold_inst, hold_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req_on});
      if (m_req_on) chk("req_addr", imem_req_addr, m_pc);
      chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_slot_v});
      if (m_slot_v) begin
        chk("inst", inst, m_inst);
        chk("inst_pc", inst_pc, m_ipc);
        chk("inst_err", {31'b0, inst_err}, {31'b0, m_ierr});
      end
    end
  end

  task automatic model_reset();
    m_pc     = 32'h8000_0000;
    m_req_on = 0;
    m_out    = 0;
    m_drop   = 0;
    m_slot_v = 0;
    mem_cnt  = 0;
  endtask

  task automatic do_reset(input int hold);
    #3;
    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    redir_valid    = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive at negedge+1, advance the model at posedge, return at the next negedge.
  task automatic cyc(input bit rdy, input bit irdy, input bit rv, input logic [31:0] rpc);
    bit          rsp_v, rsp_e, acc;
    logic [31:0] rsp_d, pc_now;
    #1;
    rsp_v = (mem_cnt == 1) || stray;
    rsp_d = rand_data ? $urandom : mem_data(mem_addr);
    rsp_e = rsp_v && ((!stray && mem_addr == err_addr) || ($urandom_range(99) < err_pct));
    stray = 0;
    imem_req_ready = rdy;
    imem_rsp_valid = rsp_v;
    imem_rsp_data  = rsp_d;
    imem_rsp_err   = rsp_e;
    inst_ready     = irdy;
    redir_valid    = rv;
    redir_pc       = rpc;
    if (imem_req_valid && rdy) begin
      fires.push_back(imem_req_addr);
      fire_cyc.push_back(cycle_no);
    end
    acc    = m_req_on && rdy;
    pc_now = m_pc;
    @(posedge clk);
    if (rv) begin
      m_pc     = {rpc[31:2], 2'b00};
      m_slot_v = 0;
      if (m_out) begin
        if (rsp_v) begin m_out = 0; m_drop = 0; m_req_on = 1; end
        else m_drop = 1;
      end else if (acc) begin
        m_out = 1; m_drop = 1; m_req_on = 0;
      end else begin
        m_req_on = 1;
      end
    end else if (m_out) begin
      if (rsp_v) begin
        m_out = 0;
        if (m_drop) begin
          m_drop = 0; m_req_on = 1;
        end else begin
          m_slot_v = 1; m_inst = rsp_d; m_ipc = m_pc; m_ierr = rsp_e;
        end
      end
    end else if (m_slot_v) begin
      if (irdy) begin m_slot_v = 0; m_pc = m_pc + 32'd4; m_req_on = 1; end
    end else if (acc) begin
      m_out = 1; m_req_on = 0;
    end else begin
      m_req_on = 1;
    end
    if (mem_cnt > 0) mem_cnt--;
    if (acc) begin
      mem_cnt  = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(3, 1));
      mem_addr = pc_now;
    end
    cycle_no++;
    @(negedge clk);
  endtask

  task automatic wait_slot(input string name);
    for (int i = 0; i < 12 && !inst_valid; i++) cyc(1, 0, 0, 32'h0);
    chk(name, {31'b0, inst_valid}, 32'd1);
  endtask

  initial begin
    lat_cfg   = 1;
    err_pct   = 0;
    rand_data = 0;
    stray     = 0;
    err_addr  = 32'h8000_0010;
    model_reset();

    // Reset values and 3-cycle steady-state throughput.
    do_reset(2);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", {31'b0, inst_err}, 32'd0);
    fires.delete();
    fire_cyc.delete();
    repeat (10) cyc(1, 1, 0, 32'h0);
    chk("fire_count", {31'b0, fires.size() >= 3}, 32'd1);
    if (fires.size() >= 3) begin
      chk("fire0", fires[0], 32'h8000_0000);
      chk("fire1", fires[1], 32'h8000_0004);
      chk("fire2", fires[2], 32'h8000_0008);
      chk("gap01", 32'(fire_cyc[1] - fire_cyc[0]), 32'd3);
      chk("gap12", 32'(fire_cyc[2] - fire_cyc[1]), 32'd3);
    end

    // Decoder stall holds the slot, then consume advances by 4.
    do_reset(1);
    wait_slot("stall_slot");
    chk("stall_pc", inst_pc, 32'h8000_0000);
    chk("stall_inst", inst, 32'h1357_9BDF ^ 32'h8000_0000);
    hold_inst = inst;
    hold_pc   = inst_pc;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 32'h0);
      chk("stall_hold_inst", inst, hold_inst);
      chk("stall_hold_pc", inst_pc, hold_pc);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    cyc(1, 1, 0, 32'h0);
    chk("after_stall_req", {31'b0, imem_req_valid}, 32'd1);
    chk("after_stall_addr", imem_req_addr, 32'h8000_0004);

    // Redirect while waiting; the late response must be discarded.
    do_reset(1);
    lat_cfg = 3;
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 0, 32'h0);
    cyc(1, 0, 1, 32'h8000_1002);
    cyc(1, 0, 0, 32'h0);
    chk("redir_wait_iv", {31'b0, inst_valid}, 32'd0);
    cyc(1, 0, 0, 32'h0);
    chk("redir_wait_drop_iv", {31'b0, inst_valid}, 32'd0);
    chk("redir_wait_req", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_wait_addr", imem_req_addr, 32'h8000_1000);
    lat_cfg = 1;

    // Redirect in FULL beats a same-cycle consume.
    do_reset(1);
    wait_slot("full_slot");
    cyc(0, 1, 1, 32'h8000_2468);
    chk("redir_full_iv", {31'b0, inst_valid}, 32'd0);
    chk("redir_full_req", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_full_addr", imem_req_addr, 32'h8000_2468);

    // Access fault is delivered normally and pc still steps by 4.
    do_reset(1);
    cyc(0, 0, 1, 32'h8000_0010);
    wait_slot("err_slot");
    chk("err_flag", {31'b0, inst_err}, 32'd1);
    chk("err_pc", inst_pc, 32'h8000_0010);
    chk("err_inst", inst, 32'h9357_9BCF);
    cyc(0, 1, 0, 32'h0);
    chk("err_next_addr", imem_req_addr, 32'h8000_0014);

    // Reset in WAIT with a non-zero slot history, then a stray response after release.
    do_reset(1);
    repeat (4) cyc(1, 1, 0, 32'h0);
    lat_cfg = 3;
    cyc(1, 1, 0, 32'h0);
    cyc(1, 1, 0, 32'h0);
    do_reset(2);
    chk("mid_rst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("mid_rst_iv", {31'b0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_pc", inst_pc, 32'd0);
    stray = 1;
    cyc(0, 1, 0, 32'h0);
    chk("stray_iv", {31'b0, inst_valid}, 32'd0);
    chk("stray_req", {31'b0, imem_req_valid}, 32'd1);
    chk("stray_addr", imem_req_addr, 32'h8000_0000);
    lat_cfg = 1;

    // PC wrap at the top of the address space.
    cyc(0, 0, 1, 32'hFFFF_FFFE);
    wait_slot("wrap_slot");
    chk("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 32'h0);
    chk("wrap_req", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Randomized traffic against the model.
    lat_cfg   = 0;
    err_pct   = 12;
    rand_data = 1;
    err_addr  = 32'h0000_0001;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      cyc($urandom_range(3) != 0, $urandom_range(2) != 0, $urandom_range(11) == 0, rpc);
      if ($urandom_range(399) == 0) begin
        do_reset(int'($urandom_range(3, 1)));
        stray = ($urandom_range(1) == 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060229_ifu.md
Name: ysyx_23060229_ifu

Overview:
- Instruction fetch unit directly upstream of the combinational decoder; owns the architectural PC.
- Issues word reads to the instruction memory port, holds one fetched instruction with its PC, presents it to the decoder over a valid/ready handshake.
- Accepts PC redirects from the execute stage for branch, jal and jalr targets.

Parameters:
- RESET_PC, 32'h8000_0000, PC after reset release.
- XLEN, 32, width of PC, address and instruction.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word address of fetch (bits [1:0] = 0).
- imem_rsp_valid  in  1  read data valid (exactly one per accepted request, any later cycle ≥1).
- imem_rsp_data  in  XLEN  fetched instruction.
- imem_rsp_err  in  1  access fault on this response.
- inst_valid  out  1  instruction slot holds data for decoder.
- inst_ready  in  1  downstream consumes slot this cycle.
- inst  out  XLEN  instruction to decoder.
- inst_pc  out  XLEN  PC of inst.
- inst_err  out  1  fetch fault attached to inst.
- redir_valid  in  1  redirect request, single-cycle pulse.
- redir_pc  in  XLEN  redirect target.

Behaviour:
- Reset (rst low, async): pc=RESET_PC; state=REQ; imem_req_valid=0; inst_valid=0; inst=0; inst_pc=0; inst_err=0; drop=0. The first request is raised the cycle after rst deasserts.
- States: REQ, WAIT, FULL.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready go to WAIT. Address is held stable until accepted.
- WAIT: imem_req_valid=0. On imem_rsp_valid with drop=0, latch inst=rsp_data, inst_pc=pc, inst_err=rsp_err, set inst_valid=1, go to FULL. With drop=1, discard the data, clear drop, go to REQ.
- FULL: inst_valid=1 and slot contents stable. On inst_ready: inst_valid←0, pc←pc+4 (mod 2^32, wrap 0xFFFF_FFFC→0), go to REQ. Minimum steady-state throughput is one instruction per 3 cycles with a 1-cycle memory; no prefetch.
- Redirect (redir_valid=1), evaluated in every state with priority over the normal transition:
  - pc←{redir_pc[31:2],2'b00}; inst_valid←0 the next cycle (any held instruction is squashed even if inst_ready is high the same cycle).
  - REQ not yet accepted → stay in REQ with the new address.
  - REQ accepted the same cycle → go to WAIT with drop=1.
  - WAIT → stay in WAIT, drop=1; if rsp_valid arrives the same cycle, discard it and go to REQ with drop=0.
  - FULL → go to REQ.
- redir_pc[1:0]≠0 is not checked here (execute raises the misalign trap); low bits are forced to 0.
- inst_err=1: slot is delivered normally with inst=rsp_data as returned; the PC still advances by 4 on consume.
- Outstanding requests never exceed 1; imem_req_valid is never high in WAIT or FULL.
- inst_valid, inst, inst_pc and inst_err are all registered outputs; there is no combinational path from imem_rsp_* to inst_*.
- Reset mid-transaction: state is cleared immediately; a late rsp_valid arriving after reset release, while in REQ, is ignored.

Decomposition:
- Shared package/macro file: ysyx_23060229_RESET_PC, IFU state encodings (IFU_REQ/IFU_WAIT/IFU_FULL), XLEN.
- No sub-module required; the one-entry instruction slot stays inline.

Test Plan:
- Reset release, 1-cycle memory, inst_ready=1 → requests at 0x80000000, 0x80000004, 0x80000008; inst_pc matches; one instruction per 3 cycles.
- Decoder stalls (inst_ready=0 for 5 cycles) in FULL → inst/inst_pc stable, no new request; consume → next address is +4.
- Redirect to 0x80001002 while in WAIT, response returns 2 cycles later → response discarded, inst_valid stays 0, next request addr 0x80001000.
- Redirect in FULL with inst_ready=1 the same cycle → slot squashed, pc not incremented, next request addr = redirect target.
- imem_rsp_err=1 at 0x80000010 → inst_valid=1, inst_err=1, inst_pc=0x80000010; next fetch 0x80000014.
- Assert rst low during WAIT, then release → outputs at reset values, first request at 0x80000000, stray response ignored; pc=0xFFFFFFFC consume → wraps to 0x00000000.
